// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Pipeline stage register with valid/ready flow control, flush and bubble
// insertion. Sits between two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB)
// so that hazards can stall the pipe and taken branches/jumps/exceptions can
// squash it without per-stage glue logic.
//
// With SKID_EN=1 a second (skid) entry absorbs the payload that arrives in the
// cycle the downstream stalls. That lets in_ready_o come straight from a flop,
// so no ready path runs combinationally through the stage. With SKID_EN=0 the
// stage holds one entry and in_ready_o is combinational from out_ready_i.
//
// Ports:
//   clk          in   1       clock, rising edge
//   rst          in   1       synchronous reset, active-low
//   flush_i      in   1       squash stage contents
//   in_valid_i   in   1       upstream payload valid
//   in_ready_o   out  1       stage can accept a payload this cycle
//   in_data_i    in   DATA_W  upstream payload
//   out_valid_o  out  1       downstream payload valid
//   out_ready_i  in   1       downstream accepts payload (0 = stall)
//   out_data_o   out  DATA_W  payload to next stage, BUBBLE_VAL when invalid
//   count_o      out  2       occupancy, 0..2 (0..1 when SKID_EN=0)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned          DATA_W     = 64,
    parameter logic [DATA_W-1:0]    BUBBLE_VAL = {DATA_W{1'b0}},
    parameter bit                   SKID_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        count_o
);

    if (SKID_EN) begin : g_skid

        // State encoding equals occupancy.
        typedef enum logic [1:0] {
            ST_EMPTY = 2'd0,
            ST_FULL  = 2'd1,
            ST_SKID  = 2'd2
        } state_e;

        state_e            state_q, state_d;
        logic [DATA_W-1:0] main_q, main_d;
        logic [DATA_W-1:0] skid_q, skid_d;
        logic              in_ready_q, in_ready_d;
        logic              out_valid_q, out_valid_d;
        logic [1:0]        count_q, count_d;
        logic              in_xfer_s;
        logic              out_xfer_s;

        assign in_xfer_s  = in_valid_i & in_ready_q;
        assign out_xfer_s = out_valid_q & out_ready_i;

        // Next-state and next-data computation for the skid state machine.
        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            if (flush_i) begin
                // Anything accepted this cycle is dropped together with the
                // stage contents.
                state_d = ST_EMPTY;
                main_d  = BUBBLE_VAL;
                skid_d  = BUBBLE_VAL;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (in_xfer_s) begin
                            state_d = ST_FULL;
                            main_d  = in_data_i;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (in_xfer_s && out_xfer_s) begin
                            state_d = ST_FULL;
                            main_d  = in_data_i;
                        end else if (in_xfer_s) begin
                            // Downstream stalled while a new payload arrived:
                            // park it in the skid entry.
                            state_d = ST_SKID;
                            skid_d  = in_data_i;
                        end else if (out_xfer_s) begin
                            state_d = ST_EMPTY;
                        end else begin
                            state_d = ST_FULL;
                        end
                    end
                    ST_SKID: begin
                        // in_ready_o is low here, so only the output can move.
                        if (out_xfer_s) begin
                            state_d = ST_FULL;
                            main_d  = skid_q;
                        end else begin
                            state_d = ST_SKID;
                        end
                    end
                    default: begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE_VAL;
                        skid_d  = BUBBLE_VAL;
                    end
                endcase
            end
        end

        // Registered outputs derived from the next state, so every output
        // port comes straight from a flop.
        always_comb begin
            out_valid_d = (state_d != ST_EMPTY);
            in_ready_d  = (state_d != ST_SKID);
            case (state_d)
                ST_EMPTY: count_d = 2'd0;
                ST_FULL:  count_d = 2'd1;
                ST_SKID:  count_d = 2'd2;
                default:  count_d = 2'd0;
            endcase
        end

        // State, payload and output flops with synchronous active-low reset.
        always_ff @(posedge clk) begin
            if (!rst) begin
                state_q     <= ST_EMPTY;
                main_q      <= BUBBLE_VAL;
                skid_q      <= BUBBLE_VAL;
                in_ready_q  <= 1'b1;
                out_valid_q <= 1'b0;
                count_q     <= 2'd0;
            end else begin
                state_q     <= state_d;
                main_q      <= main_d;
                skid_q      <= skid_d;
                in_ready_q  <= in_ready_d;
                out_valid_q <= out_valid_d;
                count_q     <= count_d;
            end
        end

        assign in_ready_o  = in_ready_q;
        assign out_valid_o = out_valid_q;
        assign count_o     = count_q;
        // Mux keeps stale or never-loaded payload bits off the output.
        assign out_data_o  = out_valid_q ? main_q : BUBBLE_VAL;

    end else begin : g_single

        logic [DATA_W-1:0] main_q, main_d;
        logic              valid_q, valid_d;
        logic              in_ready_s;
        logic              in_xfer_s;
        logic              out_xfer_s;

        // Accept when empty or when the current entry leaves this cycle.
        assign in_ready_s = ~valid_q | out_ready_i;
        assign in_xfer_s  = in_valid_i & in_ready_s;
        assign out_xfer_s = valid_q & out_ready_i;

        // Next-state computation for the single entry.
        always_comb begin
            main_d  = main_q;
            valid_d = valid_q;
            if (flush_i) begin
                main_d  = BUBBLE_VAL;
                valid_d = 1'b0;
            end else if (in_xfer_s) begin
                main_d  = in_data_i;
                valid_d = 1'b1;
            end else if (out_xfer_s) begin
                valid_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end
        end

        // Entry flops with synchronous active-low reset.
        always_ff @(posedge clk) begin
            if (!rst) begin
                main_q  <= BUBBLE_VAL;
                valid_q <= 1'b0;
            end else begin
                main_q  <= main_d;
                valid_q <= valid_d;
            end
        end

        assign in_ready_o  = in_ready_s;
        assign out_valid_o = valid_q;
        assign count_o     = {1'b0, valid_q};
        assign out_data_o  = valid_q ? main_q : BUBBLE_VAL;

    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int unsigned       DW  = 64;
    localparam logic [DW-1:0]     BUB = 64'h0000_0000_0000_0B0B;

    logic clk;
    logic rst;

    // SKID_EN=1 instance signals
    logic          s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [DW-1:0] s_in_data, s_out_data;
    logic [1:0]    s_count;

    // SKID_EN=0 instance signals
    logic          n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [DW-1:0] n_in_data, n_out_data;
    logic [1:0]    n_count;

    int checks;
    int failures;

    logic [DW-1:0] q_s[$];
    logic [DW-1:0] q_n[$];

    pipe_stage_reg #(.DATA_W(DW), .BUBBLE_VAL(BUB), .SKID_EN(1'b1)) u_dut_skid (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (s_flush),
        .in_valid_i (s_in_valid),
        .in_ready_o (s_in_ready),
        .in_data_i  (s_in_data),
        .out_valid_o(s_out_valid),
        .out_ready_i(s_out_ready),
        .out_data_o (s_out_data),
        .count_o    (s_count)
    );

    pipe_stage_reg #(.DATA_W(DW), .BUBBLE_VAL(BUB), .SKID_EN(1'b0)) u_dut_single (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (n_flush),
        .in_valid_i (n_in_valid),
        .in_ready_o (n_in_ready),
        .in_data_i  (n_in_data),
        .out_valid_o(n_out_valid),
        .out_ready_i(n_out_ready),
        .out_data_o (n_out_data),
        .count_o    (n_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_s(input string tag, input logic v, input logic [DW-1:0] d,
                         input logic [1:0] c, input logic r);
        chk({tag, "_s_valid"}, {63'd0, s_out_valid}, {63'd0, v});
        chk({tag, "_s_data"},  s_out_data, d);
        chk({tag, "_s_count"}, {62'd0, s_count}, {62'd0, c});
        chk({tag, "_s_ready"}, {63'd0, s_in_ready}, {63'd0, r});
    endtask

    task automatic chk_n(input string tag, input logic v, input logic [DW-1:0] d,
                         input logic [1:0] c, input logic r);
        chk({tag, "_n_valid"}, {63'd0, n_out_valid}, {63'd0, v});
        chk({tag, "_n_data"},  n_out_data, d);
        chk({tag, "_n_count"}, {62'd0, n_count}, {62'd0, c});
        chk({tag, "_n_ready"}, {63'd0, n_in_ready}, {63'd0, r});
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // ---------------- reset with traffic presented ----------------
        rst = 1'b0;
        s_flush = 1'b0; s_in_valid = 1'b1; s_in_data = 64'hDEAD; s_out_ready = 1'b1;
        n_flush = 1'b0; n_in_valid = 1'b1; n_in_data = 64'hDEAD; n_out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        s_in_valid = 1'b0;
        n_in_valid = 1'b0;
        #1;
        chk_s("reset", 1'b0, BUB, 2'd0, 1'b1);
        chk_n("reset", 1'b0, BUB, 2'd0, 1'b1);

        // ---------------- streaming, no stall ----------------
        s_in_valid = 1'b1; s_in_data = 64'h1;
        tick();
        chk_s("stream1", 1'b1, 64'h1, 2'd1, 1'b1);
        s_in_data = 64'h2;
        tick();
        chk_s("stream2", 1'b1, 64'h2, 2'd1, 1'b1);
        s_in_data = 64'h3;
        tick();
        chk_s("stream3", 1'b1, 64'h3, 2'd1, 1'b1);
        s_in_valid = 1'b0; s_in_data = 64'hFFFF_0000_FFFF_0000;
        tick();
        chk_s("stream_drain", 1'b0, BUB, 2'd0, 1'b1);

        // ---------------- stall into skid entry ----------------
        s_in_valid = 1'b1; s_in_data = 64'hA;
        tick();
        chk_s("skid_a", 1'b1, 64'hA, 2'd1, 1'b1);
        s_out_ready = 1'b0; s_in_data = 64'hB;
        tick();
        chk_s("skid_ab", 1'b1, 64'hA, 2'd2, 1'b0);
        // Offered while in_ready_o=0: must not be taken.
        s_in_data = 64'hE;
        tick();
        chk_s("skid_hold", 1'b1, 64'hA, 2'd2, 1'b0);
        s_in_valid = 1'b0; s_out_ready = 1'b1;
        tick();
        chk_s("skid_b", 1'b1, 64'hB, 2'd1, 1'b1);
        tick();
        chk_s("skid_empty", 1'b0, BUB, 2'd0, 1'b1);

        // ---------------- flush a full skid stage ----------------
        s_in_valid = 1'b1; s_in_data = 64'hA;
        tick();
        s_out_ready = 1'b0; s_in_data = 64'hB;
        tick();
        chk_s("flush_pre", 1'b1, 64'hA, 2'd2, 1'b0);
        s_flush = 1'b1; s_in_data = 64'hC;
        tick();
        chk_s("flush", 1'b0, BUB, 2'd0, 1'b1);
        s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
        tick();
        chk_s("flush_after", 1'b0, BUB, 2'd0, 1'b1);

        // ---------------- flush with in_ready_o=1 discards the input ----------------
        s_in_valid = 1'b1; s_in_data = 64'h11;
        tick();
        s_flush = 1'b1; s_in_data = 64'h22;
        tick();
        chk_s("flush_acc", 1'b0, BUB, 2'd0, 1'b1);
        s_flush = 1'b0; s_in_valid = 1'b0;
        tick();
        chk_s("flush_acc_after", 1'b0, BUB, 2'd0, 1'b1);

        // ---------------- SKID_EN=0 stall / replace ----------------
        n_in_valid = 1'b1; n_in_data = 64'h5; n_out_ready = 1'b0;
        tick();
        chk_n("single_hold5", 1'b1, 64'h5, 2'd1, 1'b0);
        n_in_data = 64'h7;
        tick();
        chk_n("single_stall", 1'b1, 64'h5, 2'd1, 1'b0);
        n_out_ready = 1'b1; n_in_data = 64'h6;
        #1;
        chk("single_ready_comb", {63'd0, n_in_ready}, 64'd1);
        tick();
        chk_n("single_replace", 1'b1, 64'h6, 2'd1, 1'b1);
        n_in_valid = 1'b0;
        tick();
        chk_n("single_empty", 1'b0, BUB, 2'd0, 1'b1);
        n_in_valid = 1'b1; n_in_data = 64'h9; n_out_ready = 1'b0;
        tick();
        n_flush = 1'b1; n_in_data = 64'hA5;
        tick();
        chk_n("single_flush", 1'b0, BUB, 2'd0, 1'b1);
        n_flush = 1'b0; n_in_valid = 1'b0; n_out_ready = 1'b1;

        // ---------------- random traffic against a queue model ----------------
        rst = 1'b0;
        tick();
        rst = 1'b1;
        q_s.delete();
        q_n.delete();
        for (int c = 0; c < 10000; c++) begin
            chk("rnd_s_valid", {63'd0, s_out_valid}, {63'd0, (q_s.size() > 0)});
            chk("rnd_s_data",  s_out_data, (q_s.size() > 0) ? q_s[0] : BUB);
            chk("rnd_s_count", {62'd0, s_count}, 64'(q_s.size()));
            chk("rnd_n_valid", {63'd0, n_out_valid}, {63'd0, (q_n.size() > 0)});
            chk("rnd_n_data",  n_out_data, (q_n.size() > 0) ? q_n[0] : BUB);
            chk("rnd_n_count", {62'd0, n_count}, 64'(q_n.size()));

            s_flush     = ($urandom_range(99) < 2);
            s_in_valid  = $urandom_range(1);
            s_out_ready = $urandom_range(1);
            s_in_data   = {$urandom, $urandom};
            n_flush     = ($urandom_range(99) < 2);
            n_in_valid  = $urandom_range(1);
            n_out_ready = $urandom_range(1);
            n_in_data   = {$urandom, $urandom};
            #1;
            chk("rnd_s_ready", {63'd0, s_in_ready}, {63'd0, (q_s.size() < 2)});
            chk("rnd_n_ready", {63'd0, n_in_ready},
                {63'd0, ((q_n.size() == 0) || n_out_ready)});

            if (s_flush) begin
                q_s.delete();
            end else begin
                logic ix, ox;
                ix = s_in_valid && (q_s.size() < 2);
                ox = (q_s.size() > 0) && s_out_ready;
                if (ox) void'(q_s.pop_front());
                if (ix) q_s.push_back(s_in_data);
            end
            if (n_flush) begin
                q_n.delete();
            end else begin
                logic ix, ox;
                ix = n_in_valid && ((q_n.size() == 0) || n_out_ready);
                ox = (q_n.size() > 0) && n_out_ready;
                if (ox) void'(q_n.pop_front());
                if (ix) q_n.push_back(n_in_data);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
